// File: rtl/alu_req_arbiter.sv
// alu_req_arbiter: round-robin sharing of one registered ALU between two requesters,
// with a tagged, backpressured response channel and a completed-op counter.
module alu_req_arbiter #(
  parameter int unsigned ALU_LAT = 1,
  parameter logic [3:0]  NOP_FUN = 4'b1111
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [15:0] req0_A,
  input  logic [15:0] req0_B,
  input  logic [3:0]  req0_fun,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [15:0] req1_A,
  input  logic [15:0] req1_B,
  input  logic [3:0]  req1_fun,
  output logic [15:0] alu_A,
  output logic [15:0] alu_B,
  output logic [3:0]  alu_fun,
  input  logic [15:0] ALU_OUT,
  input  logic        Arith_flag,
  input  logic        Logic_flag,
  input  logic        CMP_flag,
  input  logic        Shift_flag,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [15:0] rsp_data,
  output logic [3:0]  rsp_flags,
  output logic        busy,
  output logic [15:0] op_count
);
  typedef enum logic [1:0] {IDLE, EXEC, CAPT, RESP} state_t;
  state_t      state_q, state_d;
  logic        rr_ptr_q, rr_ptr_d, op_id_q, op_id_d;
  logic [2:0]  lat_cnt_q, lat_cnt_d;
  logic [15:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic [3:0]  alu_fun_q, alu_fun_d;
  logic        rsp_valid_q, rsp_valid_d, rsp_id_q, rsp_id_d;
  logic [15:0] rsp_data_q, rsp_data_d, op_count_q, op_count_d;
  logic [3:0]  rsp_flags_q, rsp_flags_d;
  logic        gnt_id, hs;
  // rr_ptr only breaks ties; a lone requester always wins
  assign gnt_id     = (req0_valid & req1_valid) ? rr_ptr_q : req1_valid;
  assign hs         = (state_q == IDLE) & (req0_valid | req1_valid) & ~RST;
  assign req0_ready = hs & ~gnt_id;
  assign req1_ready = hs & gnt_id;
  assign alu_A      = alu_a_q;
  assign alu_B      = alu_b_q;
  assign alu_fun    = alu_fun_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_data   = rsp_data_q;
  assign rsp_flags  = rsp_flags_q;
  assign busy       = state_q != IDLE;
  assign op_count   = op_count_q;
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    op_id_d     = op_id_q;
    lat_cnt_d   = lat_cnt_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_fun_d   = alu_fun_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_data_d  = rsp_data_q;
    rsp_flags_d = rsp_flags_q;
    op_count_d  = op_count_q;
    unique case (state_q)
      IDLE: if (hs) begin
        state_d   = EXEC;
        op_id_d   = gnt_id;
        alu_a_d   = gnt_id ? req1_A : req0_A;
        alu_b_d   = gnt_id ? req1_B : req0_B;
        alu_fun_d = gnt_id ? req1_fun : req0_fun;
        lat_cnt_d = 3'(ALU_LAT);
      end
      EXEC: begin
        lat_cnt_d = lat_cnt_q - 3'd1;
        state_d   = (lat_cnt_q == 3'd1) ? CAPT : EXEC;
      end
      CAPT: begin
        state_d     = RESP;
        rsp_valid_d = 1'b1;
        rsp_id_d    = op_id_q;
        rsp_data_d  = ALU_OUT;
        rsp_flags_d = {Arith_flag, Logic_flag, CMP_flag, Shift_flag};
      end
      RESP: if (rsp_ready) begin
        state_d     = IDLE;
        rsp_valid_d = 1'b0;
        op_count_d  = op_count_q + 16'd1;
        rr_ptr_d    = ~rsp_id_q;
        alu_fun_d   = NOP_FUN;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= IDLE;
      rr_ptr_q    <= 1'b0;
      op_id_q     <= 1'b0;
      lat_cnt_q   <= 3'd0;
      alu_a_q     <= 16'd0;
      alu_b_q     <= 16'd0;
      alu_fun_q   <= NOP_FUN;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_data_q  <= 16'd0;
      rsp_flags_q <= 4'd0;
      op_count_q  <= 16'd0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      op_id_q     <= op_id_d;
      lat_cnt_q   <= lat_cnt_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_fun_q   <= alu_fun_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_data_q  <= rsp_data_d;
      rsp_flags_q <= rsp_flags_d;
      op_count_q  <= op_count_d;
    end
  end
endmodule

// File: tb/tb_alu_req_arbiter.sv
// tb_alu_req_arbiter: scoreboard bench with a behavioural registered ALU and a
// transaction-level model of grant order, response contents, latency and op count.
module tb_alu_req_arbiter;
  localparam int LAT = 2;
  logic        CLK = 1'b0, RST = 1'b1;
  logic        req0_valid = 1'b0, req1_valid = 1'b0, rsp_ready = 1'b0;
  logic        req0_ready, req1_ready;
  logic [15:0] req0_A = 16'd0, req0_B = 16'd0, req1_A = 16'd0, req1_B = 16'd0;
  logic [3:0]  req0_fun = 4'd0, req1_fun = 4'd0;
  logic [15:0] alu_A, alu_B, ALU_OUT, rsp_data, op_count;
  logic [3:0]  alu_fun, rsp_flags;
  logic        Arith_flag, Logic_flag, CMP_flag, Shift_flag;
  logic        rsp_valid, rsp_id, busy;

  always #5 CLK = ~CLK;

  alu_req_arbiter #(.ALU_LAT(LAT), .NOP_FUN(4'b1111)) dut (
    .CLK(CLK), .RST(RST),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_A(req0_A), .req0_B(req0_B), .req0_fun(req0_fun),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_A(req1_A), .req1_B(req1_B), .req1_fun(req1_fun),
    .alu_A(alu_A), .alu_B(alu_B), .alu_fun(alu_fun), .ALU_OUT(ALU_OUT),
    .Arith_flag(Arith_flag), .Logic_flag(Logic_flag), .CMP_flag(CMP_flag), .Shift_flag(Shift_flag),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data),
    .rsp_flags(rsp_flags), .busy(busy), .op_count(op_count)
  );

  // {flags[3:0] = {Arith, Logic, CMP, Shift}, result[15:0]}
  function automatic logic [19:0] alu_f(input logic [15:0] a, input logic [15:0] b, input logic [3:0] fn);
    logic [15:0] r;
    logic [3:0]  fl;
    r  = 16'd0;
    fl = 4'd0;
    case (fn)
      4'd0:  r = a + b;
      4'd1:  r = a - b;
      4'd2:  r = a * b;
      4'd3:  r = a + 16'd1;
      4'd4:  r = a & b;
      4'd5:  r = a | b;
      4'd6:  r = a ^ b;
      4'd7:  r = ~(a & b);
      4'd8:  r = {15'd0, a == b};
      4'd9:  r = {15'd0, a > b};
      4'd10: r = {15'd0, a < b};
      4'd11: r = {15'd0, a != b};
      4'd12: r = a << 1;
      4'd13: r = a >> 1;
      4'd14: r = {a[14:0], a[15]};
      default: r = 16'd0;
    endcase
    if (fn <= 4'd3) fl = 4'b1000;
    else if (fn <= 4'd7) fl = 4'b0100;
    else if (fn <= 4'd11) fl = 4'b0010;
    else if (fn <= 4'd14) fl = 4'b0001;
    return {fl, r};
  endfunction

  logic [19:0] pipe [LAT];
  always @(posedge CLK) begin
    pipe[0] <= alu_f(alu_A, alu_B, alu_fun);
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign {Arith_flag, Logic_flag, CMP_flag, Shift_flag, ALU_OUT} = pipe[LAT-1];

  typedef struct {
    logic        id;
    logic [15:0] d;
    logic [3:0]  f;
    int          c;
  } exp_t;
  exp_t        q[$];
  int          vecs = 0, errs = 0, cyc = 0;
  logic [15:0] cnt_m = 16'd0;
  logic        busy_m = 1'b0, rr_m = 1'b0, id_m = 1'b0;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", n, act, exp, cyc);
    end
  endtask

  // Transaction model: who should be granted, when the block is busy, what each op returns
  initial begin : model
    logic g;
    exp_t e;
    forever begin
      @(negedge CLK);
      if (RST) begin
        q.delete();
        busy_m = 1'b0;
        rr_m   = 1'b0;
      end else begin
        g = (req0_valid & req1_valid) ? rr_m : req1_valid;
        chk("req0_ready", req0_ready, !busy_m && req0_valid && !g);
        chk("req1_ready", req1_ready, !busy_m && req1_valid && g);
        chk("busy", busy, busy_m);
        if (!busy_m && (req0_valid || req1_valid)) begin
          e.id = g;
          {e.f, e.d} = g ? alu_f(req1_A, req1_B, req1_fun) : alu_f(req0_A, req0_B, req0_fun);
          e.c = cyc;
          q.push_back(e);
          busy_m = 1'b1;
          id_m   = g;
        end else if (busy_m && rsp_valid && rsp_ready) begin
          busy_m = 1'b0;
          rr_m   = ~id_m;
        end
      end
    end
  end

  initial begin : monitor
    bit   seen;
    exp_t e;
    seen = 1'b0;
    forever begin
      @(negedge CLK);
      if (RST) begin
        seen  = 1'b0;
        cnt_m = 16'd0;
      end else if (rsp_valid) begin
        if (q.size() == 0) chk("rsp_unexpected", rsp_valid, 0);
        else begin
          chk("rsp_id", rsp_id, q[0].id);
          chk("rsp_data", rsp_data, q[0].d);
          chk("rsp_flags", rsp_flags, q[0].f);
          chk("op_count", op_count, cnt_m);
          if (!seen) chk("rsp_latency", cyc - q[0].c, LAT + 2);
          seen = 1'b1;
          if (rsp_ready) begin
            e = q.pop_front();
            cnt_m++;
            seen = 1'b0;
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input bit id, input logic [15:0] a, input logic [15:0] b, input logic [3:0] fn);
    if (id) begin req1_valid = 1'b1; req1_A = a; req1_B = b; req1_fun = fn; end
    else begin req0_valid = 1'b1; req0_A = a; req0_B = b; req0_fun = fn; end
  endtask

  task automatic wait_acc(input bit id);
    bit acc;
    int n;
    acc = 1'b0;
    n = 0;
    while (!acc && n < 100) begin
      @(negedge CLK);
      acc = id ? (req1_valid & req1_ready) : (req0_valid & req0_ready);
      n++;
    end
    if (!acc) chk("accept_timeout", id ? req1_ready : req0_ready, 1);
    tick();
    if (id) req1_valid = 1'b0; else req0_valid = 1'b0;
  endtask

  task automatic issue(input bit id, input logic [15:0] a, input logic [15:0] b, input logic [3:0] fn);
    drive(id, a, b, fn);
    wait_acc(id);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    do begin @(negedge CLK); n++; end while ((busy || rsp_valid) && n < 300);
    if (busy || rsp_valid) chk("idle_timeout", busy, 0);
    tick();
  endtask

  // Reset with both requests pending: no ready may appear, then every output must be at its reset value
  task automatic do_reset();
    RST = 1'b1;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    @(negedge CLK);
    chk("rst_req0_ready", req0_ready, 0);
    chk("rst_req1_ready", req1_ready, 0);
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    RST = 1'b0;
    @(negedge CLK);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_id", rsp_id, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_rsp_flags", rsp_flags, 0);
    chk("rst_busy", busy, 0);
    chk("rst_op_count", op_count, 0);
    chk("rst_alu_A", alu_A, 0);
    chk("rst_alu_B", alu_B, 0);
    chk("rst_alu_fun", alu_fun, 4'b1111);
    tick();
  endtask

  initial begin : stim
    bit a0, a1;
    repeat (3) tick();
    do_reset();
    rsp_ready = 1'b1;
    issue(0, 16'd14, 16'd7, 4'b0000);
    wait_idle();
    do_reset();
    drive(0, 16'd14, 16'd7, 4'b0010);
    drive(1, 16'd14, 16'd7, 4'b0100);
    wait_acc(0);
    drive(0, 16'd14, 16'd7, 4'b0001);
    wait_acc(1);
    wait_acc(0);
    wait_idle();
    rsp_ready = 1'b0;
    drive(1, 16'd12, 16'd3, 4'b1101);
    drive(0, 16'd3, 16'd4, 4'b0000);
    wait_acc(1);
    for (int n = 0; n < 50 && !rsp_valid; n++) @(negedge CLK);
    repeat (5) @(negedge CLK);
    tick();
    rsp_ready = 1'b1;
    wait_acc(0);
    wait_idle();
    issue(1, 16'($urandom), 16'($urandom), 4'b1111);
    wait_idle();
    drive(0, 16'd100, 16'd23, 4'b0000);
    wait_acc(0);
    RST = 1'b1;
    tick();
    RST = 1'b0;
    do_reset();
    issue(1, 16'd5, 16'd9, 4'b0000);
    wait_idle();
    force dut.op_count_q = 16'hFFFF;
    cnt_m = 16'hFFFF;
    tick();
    release dut.op_count_q;
    issue(0, 16'd1, 16'd2, 4'b0101);
    wait_idle();
    chk("op_count_wrap", op_count, 0);
    for (int k = 0; k < 1500; k++) begin
      @(negedge CLK);
      a0 = req0_valid & req0_ready;
      a1 = req1_valid & req1_ready;
      tick();
      RST = ($urandom_range(0, 299) == 0);
      rsp_ready = ($urandom_range(0, 3) != 0);
      if (a0 || !req0_valid) begin
        req0_valid = 1'($urandom_range(0, 1));
        req0_A = 16'($urandom); req0_B = 16'($urandom); req0_fun = 4'($urandom_range(0, 15));
      end else if (busy) req0_A = 16'($urandom);
      if (a1 || !req1_valid) begin
        req1_valid = 1'($urandom_range(0, 1));
        req1_A = 16'($urandom); req1_B = 16'($urandom); req1_fun = 4'($urandom_range(0, 15));
      end else if (busy) req1_B = 16'($urandom);
    end
    RST = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rsp_ready = 1'b1;
    wait_idle();
    chk("queue_empty", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
